// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue.
// Holds the stall polarity, the bubble word and the default bus widths.
package if_id_queue_pkg;

  localparam logic        NoStop       = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam int          InstAddrBusW = 32;
  localparam int          InstBusW     = 32;

  // Decode may take a new instruction only when its stall bit is clear.
  function automatic logic isAdvance(input logic decodeStall);
    return decodeStall == NoStop;
  endfunction

endpackage

// File: rtl/if_id_queue_pipe_fifo.sv
// pipe_fifo: circular buffer of {pc,inst} entries with occupancy count and full/empty flags.
// A clear empties the buffer and drops any same-cycle push or pop.
module pipe_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 64,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              doPush;
  logic              doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];
  assign doPush  = push_i & ~full_o & ~clear_i;
  assign doPop   = pop_i & ~empty_o & ~clear_i;

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (clear_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling stage: DEPTH-entry instruction queue feeding a registered decode slot.
// Define IFID_BYPASS_EN to load fetch straight into decode when the queue is empty.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter  int DEPTH   = 4,
  parameter  int ADDR_W  = InstAddrBusW,
  parameter  int INST_W  = InstBusW,
  parameter  int STALL_W = 6,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               if_valid,
  input  logic [ADDR_W-1:0]  if_pc,
  input  logic [INST_W-1:0]  if_inst,
  output logic               if_ready,
  output logic               id_valid,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INST_W-1:0]  id_inst,
  output logic [CNT_W-1:0]   q_count
);

  logic                     advance;
  logic                     fifoFull;
  logic                     fifoEmpty;
  logic                     takeBypass;
  logic                     fifoPush;
  logic                     fifoPop;
  logic [ADDR_W+INST_W-1:0] fifoRdata;
  logic                     idValid_q, idValid_d;
  logic [ADDR_W-1:0]        idPc_q, idPc_d;
  logic [INST_W-1:0]        idInst_q, idInst_d;
  logic                     stall_unused;

  // Only the decode stall bit matters here; fetch stalls arrive as if_valid=0.
  assign stall_unused = ^{stall[STALL_W-1:3], stall[1:0]};
  assign advance      = isAdvance(stall[2]);

`ifdef IFID_BYPASS_EN
  assign takeBypass = advance & fifoEmpty & if_valid & ~flush;
`else
  assign takeBypass = 1'b0;
`endif

  assign if_ready = ~fifoFull;
  assign fifoPush = if_valid & ~fifoFull & ~flush & ~takeBypass;
  assign fifoPop  = advance & ~fifoEmpty & ~flush;

  pipe_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ADDR_W + INST_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .wdata_i ({if_pc, if_inst}),
    .rdata_o (fifoRdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (q_count)
  );

  // Flush beats stall, stall beats pop; an empty advancing queue yields a bubble.
  always_comb begin
    idValid_d = idValid_q;
    idPc_d    = idPc_q;
    idInst_d  = idInst_q;
    if (flush) begin
      idValid_d = 1'b0;
      idPc_d    = '0;
      idInst_d  = INST_W'(ZeroWord);
    end else if (advance) begin
      if (!fifoEmpty) begin
        idValid_d          = 1'b1;
        {idPc_d, idInst_d} = fifoRdata;
      end
`ifdef IFID_BYPASS_EN
      else if (if_valid) begin
        idValid_d = 1'b1;
        idPc_d    = if_pc;
        idInst_d  = if_inst;
      end
`endif
      else begin
        idValid_d = 1'b0;
        idPc_d    = '0;
        idInst_d  = INST_W'(ZeroWord);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idValid_q <= 1'b0;
      idPc_q    <= '0;
      idInst_q  <= INST_W'(ZeroWord);
    end else begin
      idValid_q <= idValid_d;
      idPc_q    <= idPc_d;
      idInst_q  <= idInst_d;
    end
  end

  assign id_valid = idValid_q;
  assign id_pc    = idPc_q;
  assign id_inst  = idInst_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: expected PCs are queued as fetches are driven
// and popped as decode presents them.
module tb_if_id_queue;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 32;
  localparam int INST_W  = 32;
  localparam int STALL_W = 6;
  localparam int CNT_W   = 3;
  localparam logic [STALL_W-1:0] STALL_DEC = 6'b000100;
  localparam logic [STALL_W-1:0] STALL_IF  = 6'b000010;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               if_valid;
  logic [ADDR_W-1:0]  if_pc;
  logic [INST_W-1:0]  if_inst;
  logic               if_ready;
  logic               id_valid;
  logic [ADDR_W-1:0]  id_pc;
  logic [INST_W-1:0]  id_inst;
  logic [CNT_W-1:0]   q_count;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sbQ[$];
  logic [31:0] exp;

  if_id_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W), .STALL_W(STALL_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instOf(input logic [31:0] pc);
    return {pc[15:0], 16'hC0DE};
  endfunction

  task automatic fetch(input logic v, input logic [31:0] pc);
    if_valid = v;
    if_pc    = pc;
    if_inst  = instOf(pc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = '0; flush = 1'b0; fetch(1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (id_valid !== 1'b0 || id_inst !== 32'h0 || q_count !== 3'd0 || if_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_init got valid=%b inst=%h count=%0d ready=%b want 0/0/0/1",
               id_valid, id_inst, q_count, if_ready);
    end
    @(negedge clk); rst = 1'b0;
    stall = STALL_DEC; fetch(1'b1, 32'h10); tick;
    stall = '0; fetch(1'b0, 32'h0); tick;
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h10) begin
      failures++;
      $display("[TB] FAIL reset_pre_present got valid=%b pc=%h want 1/00000010", id_valid, id_pc);
    end
    stall = STALL_DEC;
    for (int i = 0; i < 3; i++) begin
      fetch(1'b1, 32'h20 + 32'(4 * i));
      tick;
    end
    fetch(1'b0, 32'h0);
    checks++;
    if (q_count !== 3'd3) begin
      failures++;
      $display("[TB] FAIL reset_pre_count got %0d want 3", q_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0 || q_count !== 3'd0 || if_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_async got valid=%b pc=%h inst=%h count=%0d ready=%b want 0/0/0/0/1",
               id_valid, id_pc, id_inst, q_count, if_ready);
    end
    @(negedge clk); rst = 1'b0; stall = '0;
    sbQ.delete();
  endtask

  task automatic test_fill;
    stall = STALL_DEC;
    for (int i = 0; i < DEPTH; i++) begin
      fetch(1'b1, 32'h100 + 32'(4 * i));
      sbQ.push_back(32'h100 + 32'(4 * i));
      tick;
    end
    checks++;
    if (q_count !== 3'd4 || if_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fill_full got count=%0d ready=%b want 4/0", q_count, if_ready);
    end
    fetch(1'b1, 32'h110); tick;
    checks++;
    if (q_count !== 3'd4) begin
      failures++;
      $display("[TB] FAIL fill_fifth_rejected got count=%0d want 4", q_count);
    end
    fetch(1'b0, 32'h0); stall = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tick;
      checks++;
      if (sbQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL fill_sb_underflow got pc=%h want none", id_pc);
      end else begin
        exp = sbQ.pop_front();
        if (id_valid !== 1'b1 || id_pc !== exp || id_inst !== instOf(exp)) begin
          failures++;
          $display("[TB] FAIL fill_drain%0d got valid=%b pc=%h inst=%h want 1/%h/%h",
                   i, id_valid, id_pc, id_inst, exp, instOf(exp));
        end
      end
    end
    tick;
    checks++;
    if (id_valid !== 1'b0 || id_inst !== 32'h0 || q_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL fill_bubble got valid=%b inst=%h count=%0d want 0/0/0", id_valid, id_inst, q_count);
    end
  endtask

  task automatic test_back_to_back;
    stall = STALL_DEC;
    for (int i = 0; i < 2; i++) begin
      fetch(1'b1, 32'h300 + 32'(4 * i));
      sbQ.push_back(32'h300 + 32'(4 * i));
      tick;
    end
    stall = STALL_IF;
    for (int i = 0; i < 10; i++) begin
      fetch(1'b1, 32'h308 + 32'(4 * i));
      sbQ.push_back(32'h308 + 32'(4 * i));
      tick;
      checks++;
      if (sbQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL b2b_sb_underflow got pc=%h want none", id_pc);
      end else begin
        exp = sbQ.pop_front();
        if (q_count !== 3'd2 || id_valid !== 1'b1 || id_pc !== exp || id_inst !== instOf(exp)) begin
          failures++;
          $display("[TB] FAIL b2b_step%0d got count=%0d valid=%b pc=%h want 2/1/%h",
                   i, q_count, id_valid, id_pc, exp);
        end
      end
    end
    fetch(1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (sbQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL b2b_tail_underflow got pc=%h want none", id_pc);
      end else begin
        exp = sbQ.pop_front();
        if (id_valid !== 1'b1 || id_pc !== exp) begin
          failures++;
          $display("[TB] FAIL b2b_tail%0d got valid=%b pc=%h want 1/%h", i, id_valid, id_pc, exp);
        end
      end
    end
    stall = '0;
    tick;
  endtask

  task automatic test_flush;
    stall = STALL_DEC;
    for (int i = 0; i < 3; i++) begin
      fetch(1'b1, 32'h500 + 32'(4 * i));
      tick;
    end
    checks++;
    if (q_count !== 3'd3) begin
      failures++;
      $display("[TB] FAIL flush_pre_count got %0d want 3", q_count);
    end
    stall = '0; flush = 1'b1; fetch(1'b1, 32'h200);
    tick;
    checks++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0 || q_count !== 3'd0 || if_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_edge got valid=%b pc=%h count=%0d ready=%b want 0/0/0/1",
               id_valid, id_pc, q_count, if_ready);
    end
    flush = 1'b0; fetch(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (id_valid !== 1'b0 || id_pc === 32'h200) begin
        failures++;
        $display("[TB] FAIL flush_after%0d got valid=%b pc=%h want 0/not 00000200", i, id_valid, id_pc);
      end
    end
  endtask

  task automatic test_bypass;
    stall = '0;
    fetch(1'b1, 32'h400);
    tick;
    fetch(1'b0, 32'h0);
`ifdef IFID_BYPASS_EN
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h400 || id_inst !== instOf(32'h400) || q_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL bypass_edgeN got valid=%b pc=%h count=%0d want 1/00000400/0", id_valid, id_pc, q_count);
    end
    tick;
    checks++;
    if (id_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bypass_after got valid=%b want 0", id_valid);
    end
`else
    checks++;
    if (id_valid !== 1'b0 || q_count !== 3'd1) begin
      failures++;
      $display("[TB] FAIL nobypass_edgeN got valid=%b count=%0d want 0/1", id_valid, q_count);
    end
    tick;
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h400 || id_inst !== instOf(32'h400) || q_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL nobypass_edgeN1 got valid=%b pc=%h count=%0d want 1/00000400/0", id_valid, id_pc, q_count);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_fill;
    test_back_to_back;
    test_flush;
    test_bypass;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
